// File: rtl/pcs_loopback_ctrl_if.sv
// Stream bundles around the TX-side loopback selector: MAC TX input, loopback input, TX PCS output.
interface pcs_loopback_ctrl_if #(
   parameter int DATA_W      = 64,
   parameter int LANE0_CNT_N = 1
);
   localparam int KEEP_W = DATA_W / 8;

   logic                   mac_ctrl_i;
   logic                   mac_idle_i;
   logic                   mac_term_i;
   logic                   mac_err_i;
   logic [LANE0_CNT_N-1:0] mac_start_i;
   logic [DATA_W-1:0]      mac_data_i;
   logic [KEEP_W-1:0]      mac_keep_i;
   logic                   mac_ready_o;

   logic                   lb_ctrl_i;
   logic                   lb_idle_i;
   logic                   lb_term_i;
   logic                   lb_err_i;
   logic [LANE0_CNT_N-1:0] lb_start_i;
   logic [DATA_W-1:0]      lb_data_i;
   logic [KEEP_W-1:0]      lb_keep_i;

   logic                   pcs_tx_ctrl_o;
   logic                   pcs_tx_idle_o;
   logic                   pcs_tx_term_o;
   logic                   pcs_tx_err_o;
   logic [LANE0_CNT_N-1:0] pcs_tx_start_o;
   logic [DATA_W-1:0]      pcs_tx_data_o;
   logic [KEEP_W-1:0]      pcs_tx_keep_o;

   modport master (
      output mac_ctrl_i, mac_idle_i, mac_term_i, mac_err_i, mac_start_i, mac_data_i, mac_keep_i,
      output lb_ctrl_i, lb_idle_i, lb_term_i, lb_err_i, lb_start_i, lb_data_i, lb_keep_i,
      input  mac_ready_o,
      input  pcs_tx_ctrl_o, pcs_tx_idle_o, pcs_tx_term_o, pcs_tx_err_o,
      input  pcs_tx_start_o, pcs_tx_data_o, pcs_tx_keep_o
   );

   modport slave (
      input  mac_ctrl_i, mac_idle_i, mac_term_i, mac_err_i, mac_start_i, mac_data_i, mac_keep_i,
      input  lb_ctrl_i, lb_idle_i, lb_term_i, lb_err_i, lb_start_i, lb_data_i, lb_keep_i,
      output mac_ready_o,
      output pcs_tx_ctrl_o, pcs_tx_idle_o, pcs_tx_term_o, pcs_tx_err_o,
      output pcs_tx_start_o, pcs_tx_data_o, pcs_tx_keep_o
   );
endinterface

// File: rtl/pcs_loopback_ctrl.sv
// Selects MAC or PCS RX->TX loopback as the TX PCS source, switching only on idle blocks.
// Optional macro PCS_LOOPBACK_ERR_CNT_EN adds the lb_err_cnt_o loopback error counter.
module pcs_loopback_ctrl #(
   parameter int DATA_W      = 64,
   parameter int LANE0_CNT_N = 1,
   parameter int LOCK_CYC    = 64
) (
   input  logic               tx_clk,
   input  logic               tx_reset,
   input  logic               lpbk_en_i,
   input  logic               rx_lock_i,
   pcs_loopback_ctrl_if.slave bus,
`ifdef PCS_LOOPBACK_ERR_CNT_EN
   output logic [15:0]        lb_err_cnt_o,
`endif
   output logic               lpbk_active_o,
   output logic               lock_lost_o
);
   localparam int          KEEP_W     = DATA_W / 8;
   localparam logic [15:0] LOCK_MAX_C = 16'(LOCK_CYC - 1);

   typedef enum logic [2:0] {
      ST_NORMAL    = 3'd0,
      ST_DRAIN_MAC = 3'd1,
      ST_LOCK_WAIT = 3'd2,
      ST_ALIGN     = 3'd3,
      ST_LOOPBACK  = 3'd4,
      ST_DRAIN_LB  = 3'd5
   } state_t;

   typedef struct packed {
      logic                   ctrl;
      logic                   idle;
      logic                   term;
      logic                   err;
      logic [LANE0_CNT_N-1:0] start;
      logic [DATA_W-1:0]      data;
      logic [KEEP_W-1:0]      keep;
   } beat_t;

   function automatic beat_t ctl_beat(input logic idle, input logic err);
      beat_t b;
      b.ctrl  = 1'b1;
      b.idle  = idle;
      b.term  = 1'b0;
      b.err   = err;
      b.start = {LANE0_CNT_N{1'b0}};
      b.data  = {DATA_W{1'b0}};
      b.keep  = {KEEP_W{1'b0}};
      return b;
   endfunction

   state_t      state_r;
   state_t      state_s;
   logic [15:0] cnt_r;
   beat_t       beat_s;
   beat_t       out_r;
   beat_t       mac_beat_s;
   beat_t       lb_beat_s;
   logic        lost_set_s;
   logic        lpbk_en_d_r;
   logic        lpbk_rise_s;
   logic        mac_ready_r;
   logic        lpbk_active_r;
   logic        lock_lost_r;

   assign mac_beat_s  = {bus.mac_ctrl_i, bus.mac_idle_i, bus.mac_term_i, bus.mac_err_i,
                         bus.mac_start_i, bus.mac_data_i, bus.mac_keep_i};
   assign lb_beat_s   = {bus.lb_ctrl_i, bus.lb_idle_i, bus.lb_term_i, bus.lb_err_i,
                         bus.lb_start_i, bus.lb_data_i, bus.lb_keep_i};
   assign lpbk_rise_s = lpbk_en_i & ~lpbk_en_d_r;

   // Next-state and source selection; lock loss outranks any lpbk_en_i change.
   always_comb begin
      state_s    = state_r;
      beat_s     = ctl_beat(1'b1, 1'b0);
      lost_set_s = 1'b0;
      case (state_r)
         ST_NORMAL: begin
            beat_s = mac_beat_s;
            if (lpbk_en_i) state_s = ST_DRAIN_MAC;
            else           state_s = ST_NORMAL;
         end
         ST_DRAIN_MAC: begin
            beat_s = mac_beat_s;
            if (!lpbk_en_i)          state_s = ST_NORMAL;
            else if (bus.mac_idle_i) state_s = ST_LOCK_WAIT;
            else                     state_s = ST_DRAIN_MAC;
         end
         ST_LOCK_WAIT: begin
            if (!lpbk_en_i)                             state_s = ST_NORMAL;
            else if (rx_lock_i && (cnt_r == LOCK_MAX_C)) state_s = ST_ALIGN;
            else                                        state_s = ST_LOCK_WAIT;
         end
         ST_ALIGN: begin
            if (!rx_lock_i)      state_s = ST_LOCK_WAIT;
            else if (!lpbk_en_i) state_s = ST_NORMAL;
            else if (bus.lb_idle_i) begin
               beat_s  = lb_beat_s;
               state_s = ST_LOOPBACK;
            end else begin
               state_s = ST_ALIGN;
            end
         end
         ST_LOOPBACK: begin
            if (!rx_lock_i) begin
               beat_s     = ctl_beat(1'b0, 1'b1);
               lost_set_s = 1'b1;
               state_s    = ST_LOCK_WAIT;
            end else begin
               beat_s = lb_beat_s;
               if (!lpbk_en_i) state_s = ST_DRAIN_LB;
               else            state_s = ST_LOOPBACK;
            end
         end
         ST_DRAIN_LB: begin
            if (!rx_lock_i) begin
               beat_s     = ctl_beat(1'b0, 1'b1);
               lost_set_s = 1'b1;
               state_s    = ST_NORMAL;
            end else begin
               beat_s = lb_beat_s;
               if (bus.lb_idle_i) state_s = ST_NORMAL;
               else               state_s = ST_DRAIN_LB;
            end
         end
         default: begin
            beat_s  = ctl_beat(1'b1, 1'b0);
            state_s = ST_NORMAL;
         end
      endcase
   end

   // State register and registered stream/status outputs.
   always_ff @(posedge tx_clk) begin
      if (tx_reset) begin
         state_r       <= ST_NORMAL;
         out_r         <= ctl_beat(1'b1, 1'b0);
         mac_ready_r   <= 1'b1;
         lpbk_active_r <= 1'b0;
         lpbk_en_d_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         out_r         <= beat_s;
         mac_ready_r   <= (state_s == ST_NORMAL) || (state_s == ST_DRAIN_MAC);
         lpbk_active_r <= (state_s == ST_LOOPBACK) || (state_s == ST_DRAIN_LB);
         lpbk_en_d_r   <= lpbk_en_i;
      end
   end

   // Consecutive-lock counter, live only in LOCK_WAIT and saturating at the qualify point.
   always_ff @(posedge tx_clk) begin
      if (tx_reset)                                    cnt_r <= 16'd0;
      else if ((state_r != ST_LOCK_WAIT) || !rx_lock_i) cnt_r <= 16'd0;
      else if (cnt_r != LOCK_MAX_C)                    cnt_r <= cnt_r + 16'd1;
      else                                             cnt_r <= cnt_r;
   end

   // Sticky lock-loss flag; a fresh loopback request clears it.
   always_ff @(posedge tx_clk) begin
      if (tx_reset)         lock_lost_r <= 1'b0;
      else if (lost_set_s)  lock_lost_r <= 1'b1;
      else if (lpbk_rise_s) lock_lost_r <= 1'b0;
      else                  lock_lost_r <= lock_lost_r;
   end

`ifdef PCS_LOOPBACK_ERR_CNT_EN
   logic [15:0] err_cnt_r;
   logic        err_inc_s;

   // While active, the loopback beat is forwarded exactly when lock is still present.
   assign err_inc_s = ((state_r == ST_LOOPBACK) || (state_r == ST_DRAIN_LB)) && rx_lock_i && bus.lb_err_i;

   // Saturating count of forwarded errored loopback beats.
   always_ff @(posedge tx_clk) begin
      if (tx_reset)                                err_cnt_r <= 16'd0;
      else if (lpbk_rise_s)                        err_cnt_r <= 16'd0;
      else if (err_inc_s && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'd1;
      else                                         err_cnt_r <= err_cnt_r;
   end

   assign lb_err_cnt_o = err_cnt_r;
`endif

   assign bus.mac_ready_o    = mac_ready_r;
   assign bus.pcs_tx_ctrl_o  = out_r.ctrl;
   assign bus.pcs_tx_idle_o  = out_r.idle;
   assign bus.pcs_tx_term_o  = out_r.term;
   assign bus.pcs_tx_err_o   = out_r.err;
   assign bus.pcs_tx_start_o = out_r.start;
   assign bus.pcs_tx_data_o  = out_r.data;
   assign bus.pcs_tx_keep_o  = out_r.keep;
   assign lpbk_active_o      = lpbk_active_r;
   assign lock_lost_o        = lock_lost_r;
endmodule

// File: tb/tb_pcs_loopback_ctrl.sv
// Scoreboard bench for pcs_loopback_ctrl: expected beats queued at drive time, compared one cycle later.
module tb_pcs_loopback_ctrl;
   localparam int DATA_W      = 64;
   localparam int LANE0_CNT_N = 1;
   localparam int LOCK_CYC    = 4;
   localparam int KEEP_W      = DATA_W / 8;

   typedef struct packed {
      logic                   ctrl;
      logic                   idle;
      logic                   term;
      logic                   err;
      logic [LANE0_CNT_N-1:0] start;
      logic [DATA_W-1:0]      data;
      logic [KEEP_W-1:0]      keep;
   } beat_t;

   logic  tx_clk = 1'b0;
   logic  tx_reset;
   logic  lpbk_en;
   logic  rx_lock;
   logic  lpbk_active;
   logic  lock_lost;
   int    n_checks = 0;
   int    n_errors = 0;
   beat_t exp_q[$];
   beat_t IDLE_B, ERR_B, MS, MD, MT, LM, LS, LD, LT, LE;
   logic [6:0] lock_pat;

   pcs_loopback_ctrl_if #(.DATA_W(DATA_W), .LANE0_CNT_N(LANE0_CNT_N)) bus ();

`ifdef PCS_LOOPBACK_ERR_CNT_EN
   logic [15:0] lb_err_cnt;
`endif

   pcs_loopback_ctrl #(.DATA_W(DATA_W), .LANE0_CNT_N(LANE0_CNT_N), .LOCK_CYC(LOCK_CYC)) dut (
      .tx_clk        (tx_clk),
      .tx_reset      (tx_reset),
      .lpbk_en_i     (lpbk_en),
      .rx_lock_i     (rx_lock),
      .bus           (bus),
`ifdef PCS_LOOPBACK_ERR_CNT_EN
      .lb_err_cnt_o  (lb_err_cnt),
`endif
      .lpbk_active_o (lpbk_active),
      .lock_lost_o   (lock_lost)
   );

   always #5 tx_clk = ~tx_clk;

   function automatic beat_t mk(input logic c, input logic i, input logic t, input logic e,
                                input logic [LANE0_CNT_N-1:0] s, input logic [DATA_W-1:0] d,
                                input logic [KEEP_W-1:0] k);
      beat_t b;
      b.ctrl = c; b.idle = i; b.term = t; b.err = e; b.start = s; b.data = d; b.keep = k;
      return b;
   endfunction

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive(input beat_t m, input beat_t l);
      {bus.mac_ctrl_i, bus.mac_idle_i, bus.mac_term_i, bus.mac_err_i,
       bus.mac_start_i, bus.mac_data_i, bus.mac_keep_i} = m;
      {bus.lb_ctrl_i, bus.lb_idle_i, bus.lb_term_i, bus.lb_err_i,
       bus.lb_start_i, bus.lb_data_i, bus.lb_keep_i} = l;
   endtask

   task automatic cyc(input string tag, input beat_t exp);
      beat_t got;
      exp_q.push_back(exp);
      @(posedge tx_clk);
      #1;
      got = {bus.pcs_tx_ctrl_o, bus.pcs_tx_idle_o, bus.pcs_tx_term_o, bus.pcs_tx_err_o,
             bus.pcs_tx_start_o, bus.pcs_tx_data_o, bus.pcs_tx_keep_o};
      check_val(tag, 128'(got), 128'(exp_q.pop_front()));
   endtask

   task automatic step(input string tag, input beat_t m, input beat_t l, input beat_t exp, input logic rdy);
      drive(m, l);
      check_val({tag, "_rdy"}, 128'(bus.mac_ready_o), 128'(rdy));
      cyc(tag, exp);
   endtask

   initial begin
      IDLE_B = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
      ERR_B  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00);
      MS     = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hD5555555555555FB, 8'hFF);
      MD     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0123456789ABCDEF, 8'hFF);
      MT     = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h00000000FDCAFE01, 8'h0F);
      LM     = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h00000000000000A5, 8'h00);
      LS     = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hD55555555555AAFB, 8'hFF);
      LD     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFEEDFACE0BADF00D, 8'hFF);
      LT     = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h000000000000FDEE, 8'h03);
      LE     = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hBAD0BAD0BAD0BAD0, 8'hFF);

      // reset with a data beat on the MAC side: output must still be IDLE
      tx_reset = 1'b1; lpbk_en = 1'b0; rx_lock = 1'b0;
      drive(MD, LD);
      cyc("rst_beat0", IDLE_B);
      cyc("rst_beat1", IDLE_B);
      check_val("rst_rdy", 128'(bus.mac_ready_o), 128'(1'b1));
      check_val("rst_active", 128'(lpbk_active), 128'(1'b0));
      check_val("rst_lost", 128'(lock_lost), 128'(1'b0));
`ifdef PCS_LOOPBACK_ERR_CNT_EN
      check_val("rst_errcnt", 128'(lb_err_cnt), 128'(16'd0));
`endif
      tx_reset = 1'b0;

      // normal MAC frame
      step("n_start", MS, LD, MS, 1'b1);
      step("n_data", MD, LD, MD, 1'b1);
      step("n_term", MT, LD, MT, 1'b1);
      step("n_idle", IDLE_B, LD, IDLE_B, 1'b1);

      // loopback request mid frame: frame completes, then lock qualification
      lpbk_en = 1'b1; rx_lock = 1'b1;
      step("dm_start", MS, LM, MS, 1'b1);
      step("dm_data", MD, LM, MD, 1'b1);
      step("dm_term", MT, LM, MT, 1'b1);
      step("dm_idle", IDLE_B, LM, IDLE_B, 1'b1);
      lock_pat = 7'b1111011;
      for (int i = 0; i < 7; i++) begin
         rx_lock = lock_pat[i];
         step("lw_idle", MD, LM, IDLE_B, 1'b0);
         check_val("lw_active", 128'(lpbk_active), 128'(1'b0));
      end
      rx_lock = 1'b1;
      step("al_wait", MD, LD, IDLE_B, 1'b0);
      check_val("al_active0", 128'(lpbk_active), 128'(1'b0));
      step("al_go", MD, LM, LM, 1'b0);
      check_val("al_active1", 128'(lpbk_active), 128'(1'b1));

      // loopback traffic with errored beats, then lock loss
      step("lb_start", MD, LS, LS, 1'b0);
      for (int i = 0; i < 5; i++) step("lb_err", MD, LE, LE, 1'b0);
`ifdef PCS_LOOPBACK_ERR_CNT_EN
      check_val("errcnt5", 128'(lb_err_cnt), 128'(16'd5));
`endif
      rx_lock = 1'b0;
      step("ll_err", MD, LD, ERR_B, 1'b0);
      check_val("ll_lost", 128'(lock_lost), 128'(1'b1));
      check_val("ll_active", 128'(lpbk_active), 128'(1'b0));
      step("ll_idle0", MD, LM, IDLE_B, 1'b0);
      step("ll_idle1", MD, LM, IDLE_B, 1'b0);
      check_val("ll_sticky", 128'(lock_lost), 128'(1'b1));
`ifdef PCS_LOOPBACK_ERR_CNT_EN
      check_val("errcnt_hold", 128'(lb_err_cnt), 128'(16'd5));
`endif

      // re-qualify lock and resume loopback
      rx_lock = 1'b1;
      for (int i = 0; i < LOCK_CYC; i++) step("rl_idle", MD, LM, IDLE_B, 1'b0);
      step("rl_go", MD, LM, LM, 1'b0);
      check_val("rl_active", 128'(lpbk_active), 128'(1'b1));

      // loopback request dropped mid frame: drain to an idle, then MAC resumes
      step("d_start", MD, LS, LS, 1'b0);
      lpbk_en = 1'b0;
      step("d_data", MD, LD, LD, 1'b0);
      check_val("d_active", 128'(lpbk_active), 128'(1'b1));
      step("d_term", MD, LT, LT, 1'b0);
      step("d_idle", MD, LM, LM, 1'b0);
      check_val("d_active_off", 128'(lpbk_active), 128'(1'b0));
      step("m_start", MS, LD, MS, 1'b1);
      step("m_data", MD, LD, MD, 1'b1);
      step("m_term", MT, LD, MT, 1'b1);
      step("m_idle", IDLE_B, LD, IDLE_B, 1'b1);
      check_val("m_lost_sticky", 128'(lock_lost), 128'(1'b1));

      // lpbk_en toggling each cycle during a MAC frame; rising edge clears status
      lpbk_en = 1'b1;
      step("t_start", MS, LM, MS, 1'b1);
      check_val("t_lost_clr", 128'(lock_lost), 128'(1'b0));
`ifdef PCS_LOOPBACK_ERR_CNT_EN
      check_val("t_errcnt_clr", 128'(lb_err_cnt), 128'(16'd0));
`endif
      lpbk_en = 1'b0;
      step("t_d0", MD, LM, MD, 1'b1);
      lpbk_en = 1'b1;
      step("t_d1", MD, LM, MD, 1'b1);
      lpbk_en = 1'b0;
      step("t_term", MT, LM, MT, 1'b1);
      check_val("t_active", 128'(lpbk_active), 128'(1'b0));

      // reset asserted mid frame forces IDLE
      step("r_start", MS, LD, MS, 1'b1);
      tx_reset = 1'b1;
      drive(MD, LD);
      cyc("r_mid", IDLE_B);
      tx_reset = 1'b0;
      check_val("r_rdy", 128'(bus.mac_ready_o), 128'(1'b1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pcs_loopback_ctrl.md
# pcs_loopback_ctrl

Single-lane TX-side controller that selects the source of the TX PCS input stream: the MAC in normal operation, or the PCS RX→TX loopback stream during FPGA loopback testing. Switching happens only on idle control blocks, so no frame is ever truncated or spliced. Transitions into loopback are gated by a qualified RX block lock. The block sits in the `tx_clk` domain between the MAC TX interface, the loopback retiming stage and the TX PCS.

## Interface
Parameters:
- `DATA_W`, 64, data bits per beat; `KEEP_W = DATA_W/8`.
- `LANE0_CNT_N`, 1, width of the start-position field.
- `LOCK_CYC`, 64, consecutive cycles of `rx_lock_i`=1 that qualify lock; range 1..2^16-1.

Ports (every stream bundle is `ctrl`, `idle`, `term`, `err` each 1 bit, `start` LANE0_CNT_N, `data` DATA_W, `keep` KEEP_W):
- `tx_clk`  in  1  clock.
- `tx_reset`  in  1  synchronous, active-high reset.
- `lpbk_en_i`  in  1  loopback request, level, already in the `tx_clk` domain.
- `rx_lock_i`  in  1  RX block lock, already synchronised to `tx_clk`.
- `mac_*_i`  in  bundle  MAC TX stream, one beat per cycle when `mac_ready_o`=1.
- `mac_ready_o`  out  1  MAC beat accepted this cycle.
- `lb_*_i`  in  bundle  loopback stream, one beat every cycle, no backpressure.
- `pcs_tx_*_o`  out  bundle  stream to the TX PCS, registered.
- `lpbk_active_o`  out  1  high while state is LOOPBACK or DRAIN_LB, registered.
- `lock_lost_o`  out  1  sticky, set on lock loss during loopback; cleared by reset or by a rising edge of `lpbk_en_i`.

## Operation
IDLE beat: `ctrl`=1, `idle`=1, all other fields 0.
ERR beat: `ctrl`=1, `err`=1, all other fields 0.

States and transitions:
- NORMAL (reset state): forward the MAC stream; `mac_ready_o`=1. If `lpbk_en_i`=1, go to DRAIN_MAC.
- DRAIN_MAC: forward the MAC stream; `mac_ready_o`=1. When a MAC beat with `idle`=1 is forwarded, go to LOCK_WAIT. If `lpbk_en_i` drops, return to NORMAL.
- LOCK_WAIT: emit IDLE beats; `mac_ready_o`=0.
  - 16-bit counter increments while `rx_lock_i`=1 and clears to 0 on `rx_lock_i`=0.
  - When the counter equals `LOCK_CYC`-1 with `rx_lock_i`=1, go to ALIGN.
  - If `lpbk_en_i`=0, go to NORMAL.
- ALIGN: emit IDLE beats. On the first `lb_idle_i`=1 beat, forward that beat and go to LOOPBACK.
- LOOPBACK: forward the loopback stream.
  - If `rx_lock_i`=0: emit one ERR beat, set `lock_lost_o`, clear the counter, go to LOCK_WAIT.
  - Else if `lpbk_en_i`=0: go to DRAIN_LB.
- DRAIN_LB: forward the loopback stream. On the first `lb_idle_i`=1 beat, forward it and go to NORMAL. Lock loss here: emit one ERR beat, then go directly to NORMAL.

Boundary and priority rules:
- Lock loss takes priority over a `lpbk_en_i` change in the same cycle.
- Lock loss in ALIGN returns to LOCK_WAIT with no ERR beat.
- MAC beats are never dropped. Every beat accepted with `mac_ready_o`=1 is forwarded exactly once.
- The counter saturates at `LOCK_CYC`-1.
- `lpbk_en_i` toggling every cycle must never produce a mixed-source frame.

## Timing
- The stream path has exactly 1 cycle of latency: the input beat at cycle N appears on `pcs_tx_*_o` at N+1.
- `mac_ready_o` is combinational from state. It reflects the current-cycle state only, never the next state.
- Reset values: `pcs_tx_*_o` = IDLE beat, `mac_ready_o`=1, `lpbk_active_o`=0, `lock_lost_o`=0, counter 0, state NORMAL.
- Reset asserted mid-frame forces an IDLE beat on the next edge.
- Minimum NORMAL→LOOPBACK latency: `LOCK_CYC`+2 cycles after the MAC idle beat, given `lpbk_en_i` and `rx_lock_i` already high and `lb_idle_i`=1.

## Configuration
- `PCS_LOOPBACK_ERR_CNT_EN` defined: adds output `lb_err_cnt_o` [15:0].
  - Saturating count of forwarded loopback beats with `lb_err_i`=1 while `lpbk_active_o`=1.
  - Cleared by reset and by a rising edge of `lpbk_en_i`.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset with `lpbk_en_i`=0, then a 3-beat MAC frame (start, data, term) → the same 3 beats on `pcs_tx_*_o` one cycle later; `mac_ready_o`=1 throughout.
- `lpbk_en_i`=1 mid MAC frame, `LOCK_CYC`=4, `rx_lock_i`=1 → the frame completes intact, then ≥4 IDLE beats. Loopback data starts only on an `lb_idle_i` beat, and `lpbk_active_o` rises the cycle after that beat.
- `rx_lock_i` toggling 1,1,0,1,1,1,1 in LOCK_WAIT with `LOCK_CYC`=4 → ALIGN is entered only after the 4th consecutive high cycle.
- `rx_lock_i`=0 during a loopback frame → exactly one ERR beat, `lock_lost_o`=1 (sticky), IDLE beats follow, and LOCK_WAIT is re-entered.
- `lpbk_en_i`=0 during a loopback frame → the loopback frame completes, MAC traffic resumes after an `lb_idle_i` beat, and `mac_ready_o`=0 until NORMAL.
- Macro defined: 5 loopback beats with `lb_err_i`=1 → `lb_err_cnt_o`=5; a new `lpbk_en_i` rising edge clears it to 0.
